// File: rtl/pipe_pkg.sv
// Shared constants and the update-priority decode for the MIPS inter-stage pipeline registers.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LANES_DEF  = 4;
    localparam int PC_W_DEF   = 32;
    localparam int EXC_W_DEF  = 5;
    localparam int PERF_W     = 32;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int LANE_INSTR = 0;
    localparam int LANE_RS    = 1;
    localparam int LANE_RT    = 2;
    localparam int LANE_EXT   = 3;

    typedef enum logic [1:0] {
        UPD_CLEAR  = 2'd0,
        UPD_HOLD   = 2'd1,
        UPD_BUBBLE = 2'd2,
        UPD_LOAD   = 2'd3
    } upd_e;

    // Reset and flush both clear; stall outranks bubble so a stalled stage never loses its contents.
    function automatic upd_e decode_upd(input logic reset, input logic flush,
                                        input logic stall, input logic bubble);
        upd_e u;
        if (reset || flush) u = UPD_CLEAR;
        else if (stall)     u = UPD_HOLD;
        else if (bubble)    u = UPD_BUBBLE;
        else                u = UPD_LOAD;
        return u;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter used for pipeline stall/bubble statistics.
module pipe_sat_counter
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [PERF_W-1:0] count
);

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

    logic [PERF_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else if (en)
            count_q <= sat_inc(count_q);
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, bubble and flush.
// Optional stall/bubble counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int EXC_W  = EXC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall_i,
    input  logic                    bubble_i,
    input  logic                    flush_i,
    input  logic                    in_valid,
    input  logic [PC_W-1:0]         in_pc,
    input  logic                    in_bd,
    input  logic [EXC_W-1:0]        in_exc,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    output logic [PC_W-1:0]         out_pc,
    output logic [PC_W-1:0]         out_pc8,
    output logic                    out_bd,
    output logic [EXC_W-1:0]        out_exc,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [31:0]             perf_stall,
    output logic [31:0]             perf_bubble
);

    upd_e upd;

    always_comb begin
        upd = decode_upd(reset, flush_i, stall_i, bubble_i);
    end

    logic                    vld_p0;
    logic [PC_W-1:0]         pc_p0;
    logic                    bd_p0;
    logic [EXC_W-1:0]        exc_p0;
    logic [LANES*DATA_W-1:0] data_p0;

    // Stage boundary: a bubble keeps pc/bd of the stalled instruction so EPC and BD stay correct.
    always_ff @(posedge clk) begin
        unique case (upd)
            UPD_CLEAR: begin
                vld_p0  <= 1'b0;
                pc_p0   <= '0;
                bd_p0   <= 1'b0;
                exc_p0  <= EXC_W'(EXC_NONE);
                data_p0 <= '0;
            end
            UPD_HOLD: begin
                vld_p0  <= vld_p0;
                pc_p0   <= pc_p0;
                bd_p0   <= bd_p0;
                exc_p0  <= exc_p0;
                data_p0 <= data_p0;
            end
            UPD_BUBBLE: begin
                vld_p0  <= 1'b0;
                pc_p0   <= in_pc;
                bd_p0   <= in_bd;
                exc_p0  <= EXC_W'(EXC_NONE);
                data_p0 <= '0;
            end
            UPD_LOAD: begin
                vld_p0  <= in_valid;
                pc_p0   <= in_pc;
                bd_p0   <= in_bd;
                exc_p0  <= in_valid ? in_exc : EXC_W'(EXC_NONE);
                data_p0 <= in_data;
            end
            default: begin
                vld_p0  <= 1'b0;
                pc_p0   <= '0;
                bd_p0   <= 1'b0;
                exc_p0  <= EXC_W'(EXC_NONE);
                data_p0 <= '0;
            end
        endcase
    end

    assign out_valid = vld_p0;
    assign out_pc    = pc_p0;
    assign out_bd    = bd_p0;
    assign out_exc   = exc_p0;
    assign out_data  = data_p0;
    assign out_pc8   = pc_p0 + PC_W'(8);

`ifdef PIPE_STAGE_PERF_EN
    logic stall_cnt_en;
    logic bubble_cnt_en;

    // Counters are not cleared by flush; they only see the cycles where hold/bubble actually took effect.
    assign stall_cnt_en  = (upd == UPD_HOLD);
    assign bubble_cnt_en = (upd == UPD_BUBBLE);

    pipe_sat_counter u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (stall_cnt_en),
        .count (perf_stall)
    );

    pipe_sat_counter u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (bubble_cnt_en),
        .count (perf_bubble)
    );
`else
    assign perf_stall  = '0;
    assign perf_bubble = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors push expected outputs, a monitor compares each cycle.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic         clk = 1'b0;
    logic         reset, stall_i, bubble_i, flush_i, in_valid, in_bd;
    logic [31:0]  in_pc;
    logic [4:0]   in_exc;
    logic [127:0] in_data;
    logic         out_valid, out_bd;
    logic [31:0]  out_pc, out_pc8, perf_stall, perf_bubble;
    logic [4:0]   out_exc;
    logic [127:0] out_data;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .bubble_i(bubble_i), .flush_i(flush_i),
        .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc), .in_data(in_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_pc8(out_pc8), .out_bd(out_bd),
        .out_exc(out_exc), .out_data(out_data), .perf_stall(perf_stall), .perf_bubble(perf_bubble)
    );

    typedef struct packed {
        logic         v;
        logic [31:0]  pc;
        logic [31:0]  pc8;
        logic         bd;
        logic [4:0]   exc;
        logic [127:0] data;
        logic [31:0]  pst;
        logic [31:0]  pbb;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          vec_no   = 0;
    logic [31:0] m_stall  = '0;
    logic [31:0] m_bubble = '0;

    function automatic logic [127:0] mk(input logic [31:0] instr, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [31:0] ext);
        logic [127:0] d;
        d = '0;
        d[LANE_INSTR*32 +: 32] = instr;
        d[LANE_RS*32    +: 32] = rs;
        d[LANE_RT*32    +: 32] = rt;
        d[LANE_EXT*32   +: 32] = ext;
        return d;
    endfunction

    task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared half a cycle later.
    int mon_idx = 0;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("out_valid",   mon_idx, 128'(out_valid),   128'(e.v));
            chk("out_pc",      mon_idx, 128'(out_pc),      128'(e.pc));
            chk("out_pc8",     mon_idx, 128'(out_pc8),     128'(e.pc8));
            chk("out_bd",      mon_idx, 128'(out_bd),      128'(e.bd));
            chk("out_exc",     mon_idx, 128'(out_exc),     128'(e.exc));
            chk("out_data",    mon_idx, out_data,          e.data);
            chk("perf_stall",  mon_idx, 128'(perf_stall),  128'(e.pst));
            chk("perf_bubble", mon_idx, 128'(perf_bubble), 128'(e.pbb));
            mon_idx++;
        end
    end

    task automatic step(input logic r, input logic f, input logic s, input logic b,
                        input logic iv, input logic [31:0] pc, input logic bd,
                        input logic [4:0] exc, input logic [127:0] d,
                        input logic ev, input logic [31:0] epc, input logic ebd,
                        input logic [4:0] eexc, input logic [127:0] ed);
        exp_t e;
        reset = r; flush_i = f; stall_i = s; bubble_i = b;
        in_valid = iv; in_pc = pc; in_bd = bd; in_exc = exc; in_data = d;
`ifdef PIPE_STAGE_PERF_EN
        if (r) begin
            m_stall = '0; m_bubble = '0;
        end else if (!f) begin
            if (s) m_stall = (m_stall == 32'hFFFF_FFFF) ? m_stall : m_stall + 1;
            else if (b) m_bubble = (m_bubble == 32'hFFFF_FFFF) ? m_bubble : m_bubble + 1;
        end
`endif
        e.v = ev; e.pc = epc; e.pc8 = epc + 32'd8; e.bd = ebd; e.exc = eexc; e.data = ed;
        e.pst = m_stall; e.pbb = m_bubble;
        sb.push_back(e);
        vec_no++;
        @(posedge clk);
        #1;
    endtask

    logic [127:0] d1, d2, d3, d4, d5;

    initial begin
        d1 = mk(32'h2001_0005, 32'h0000_0011, 32'h0000_0022, 32'h0000_0005);
        d2 = mk(32'h8C01_0000, 32'h0, 32'h0, 32'h0);
        d3 = mk(32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        d4 = mk(32'h0000_0020, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_FFFF);
        d5 = mk(32'h0C00_0C00, 32'h1, 32'h2, 32'h3);

        //    r  f  s  b  iv pc            bd exc    data  | ev pc            ebd eexc   edata
        // reset for two cycles with a valid instruction on the inputs
        step(1, 0, 0, 0, 1, 32'h0000_3000, 0, 5'd0,  d1,    0, 32'h0,         0, 5'd0,  '0);
        step(1, 0, 0, 0, 1, 32'h0000_3000, 0, 5'd0,  d1,    0, 32'h0,         0, 5'd0,  '0);
        step(0, 0, 0, 0, 1, 32'h0000_3000, 0, 5'd0,  d1,    1, 32'h0000_3000, 0, 5'd0,  d1);
        // stall hold for three cycles while inputs move on
        step(0, 0, 0, 0, 1, 32'h0000_3004, 0, 5'd0,  d2,    1, 32'h0000_3004, 0, 5'd0,  d2);
        step(0, 0, 1, 0, 1, 32'h0000_3008, 0, 5'd0,  d3,    1, 32'h0000_3004, 0, 5'd0,  d2);
        step(0, 0, 1, 0, 1, 32'h0000_3008, 0, 5'd0,  d3,    1, 32'h0000_3004, 0, 5'd0,  d2);
        step(0, 0, 1, 0, 1, 32'h0000_3008, 0, 5'd0,  d3,    1, 32'h0000_3004, 0, 5'd0,  d2);
        // bubble keeps pc/bd, clears valid/data/exc
        step(0, 0, 0, 1, 1, 32'h0000_300C, 1, EXC_RI, d3,   0, 32'h0000_300C, 1, 5'd0,  '0);
        step(0, 0, 0, 0, 1, 32'h0000_3010, 0, 5'd0,  d4,    1, 32'h0000_3010, 0, 5'd0,  d4);
        // stall beats bubble
        step(0, 0, 1, 1, 1, 32'h0000_3014, 1, 5'd0,  d5,    1, 32'h0000_3010, 0, 5'd0,  d4);
        // flush beats stall
        step(0, 1, 1, 0, 1, 32'h0000_3014, 1, 5'd0,  d5,    0, 32'h0,         0, 5'd0,  '0);
        // exception code gated by valid
        step(0, 0, 0, 0, 0, 32'h0000_3018, 0, EXC_OV, d3,   0, 32'h0000_3018, 0, 5'd0,  d3);
        step(0, 0, 0, 0, 1, 32'h0000_301C, 1, EXC_OV, d1,   1, 32'h0000_301C, 1, EXC_OV, d1);
        // reset asserted during a stall
        step(1, 0, 1, 0, 1, 32'h0000_3020, 1, EXC_ADEL, d4, 0, 32'h0,         0, 5'd0,  '0);
        step(0, 0, 0, 0, 1, 32'h0000_3024, 0, EXC_ADES, d5, 1, 32'h0000_3024, 0, EXC_ADES, d5);
        // flush held across two cycles
        step(0, 1, 0, 1, 1, 32'h0000_3028, 1, 5'd0,  d2,    0, 32'h0,         0, 5'd0,  '0);
        step(0, 1, 0, 0, 1, 32'h0000_302C, 1, 5'd0,  d2,    0, 32'h0,         0, 5'd0,  '0);
        // pc+8 wraps
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 5'd0,  d1,    1, 32'hFFFF_FFFC, 0, 5'd0,  d1);
        step(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 1, 5'd0,  d1,    0, 32'hFFFF_FFF8, 1, 5'd0,  '0);
`ifdef PIPE_STAGE_PERF_EN
        force dut.u_bubble_cnt.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_bubble_cnt.count_q;
        m_bubble = 32'hFFFF_FFFF;
`endif
        step(0, 0, 0, 1, 1, 32'h0000_3030, 0, 5'd0,  d3,    0, 32'h0000_3030, 0, 5'd0,  '0);
        step(0, 0, 0, 0, 1, 32'h0000_3034, 0, 5'd0,  d4,    1, 32'h0000_3034, 0, 5'd0,  d4);

        reset = 0; flush_i = 0; stall_i = 0; bubble_i = 0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core, replacing the per-stage hand-written registers (D→E, E→M, M→W).
- Carries N payload lanes plus the fields every stage needs: PC, branch-delay flag, exception code and a valid bit.
- Adds hold (stall), hazard bubble insertion that preserves PC/BD for correct EPC, and exception flush.
- Sits between stage logic; controls come from the hazard unit and CP0.

Parameters:
- DATA_W, 32, width of one payload lane
- LANES, 4, number of payload lanes (D→E: instr, rs, rt, ext)
- PC_W, 32, PC width
- EXC_W, 5, exception-code width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  hold current contents
- bubble_i  in  1  load a bubble: payload, valid and exc cleared; pc and bd loaded from inputs
- flush_i  in  1  exception/eret flush: everything cleared
- in_valid  in  1  upstream instruction valid
- in_pc  in  PC_W  upstream PC
- in_bd  in  1  upstream in branch-delay slot
- in_exc  in  EXC_W  upstream exception code, 0 = none
- in_data  in  LANES*DATA_W  payload, lane k at bits [k*DATA_W +: DATA_W]
- out_valid  out  1  registered valid
- out_pc  out  PC_W  registered PC
- out_pc8  out  PC_W  out_pc + 8, combinational, modulo 2^PC_W (link address)
- out_bd  out  1  registered BD
- out_exc  out  EXC_W  registered exception code
- out_data  out  LANES*DATA_W  registered payload
- perf_stall  out  32  stall-cycle count (optional feature)
- perf_bubble  out  32  bubble-cycle count (optional feature)

Behaviour:
- Reset value of every registered output is 0: out_valid, out_pc, out_bd, out_exc, out_data. out_pc8 therefore reads 8 during reset. perf_stall and perf_bubble are also 0.
- Update priority, evaluated at posedge clk, highest first:
  1. reset: all registered outputs cleared.
  2. flush_i: all registered outputs cleared, including pc and bd.
  3. stall_i: all registers hold their value. This applies even if bubble_i is also high.
  4. bubble_i: out_valid=0, out_data=0, out_exc=0; out_pc<=in_pc, out_bd<=in_bd. This lets an interrupt that lands on a bubble report EPC and BD of the stalled instruction.
  5. otherwise (load): out_valid<=in_valid, out_pc<=in_pc, out_bd<=in_bd, out_data<=in_data. out_exc<=in_exc only if in_valid, else 0.
- Latency: exactly one cycle from input to output on a load. No combinational path from in_* to out_*.
- out_pc8 depends only on out_pc; the adder wraps, e.g. 0xFFFFFFFC → 0x00000004.
- Reset and flush held across several cycles: contents stay cleared every cycle.
- Reset asserted mid-stall: reset wins.
- The block does not check for illegal control combinations; all combinations are legal and resolved by the priority order above.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - perf_stall increments on every cycle with stall_i=1 and neither reset nor flush_i asserted.
  - perf_bubble increments on every bubble-load cycle (rule 4 taken).
  - Both are 32-bit, saturate at 0xFFFFFFFF, clear on reset, and are not cleared by flush_i.
- Not defined: perf_stall and perf_bubble are tied to constant 0. No counter flops are synthesised. Port list is unchanged.

Decomposition:
- Package pipe_pkg holds:
  - EXC_NONE = 0
  - exception-code constants (INT=0, ADEL=4, ADES=5, RI=10, OV=12)
  - lane index constants LANE_INSTR=0, LANE_RS=1, LANE_RT=2, LANE_EXT=3
  - default widths
- One sub-module, pipe_sat_counter (32-bit saturating counter with enable), instantiated twice under the macro.

Test Plan:
- Reset: drive reset=1 for 2 cycles with in_pc=0x00003000, in_valid=1 → all outputs 0, out_pc8=0x00000008. Release and load the same inputs → next cycle out_pc=0x00003000, out_valid=1.
- Stall hold: load pc=0x00003004, lane0=0x8C010000, then raise stall_i for 3 cycles while inputs change to pc=0x00003008 → outputs keep 0x00003004 and 0x8C010000 for all 3 cycles. With the macro defined, perf_stall=3.
- Bubble: in_pc=0x0000300C, in_bd=1, in_exc=10, in_valid=1, bubble_i=1 → out_valid=0, out_data=0, out_exc=0, out_pc=0x0000300C, out_bd=1.
- Priority: stall_i=1 and bubble_i=1 together → hold. flush_i=1 with stall_i=1 → all cleared, out_pc=0.
- Exception gating: in_valid=0 with in_exc=12 → out_exc=0. in_valid=1 with in_exc=12 → out_exc=12.
- Wrap and saturation: load in_pc=0xFFFFFFFC → out_pc8=0x00000004. With the macro defined, force perf_bubble to 0xFFFFFFFF and bubble again → stays 0xFFFFFFFF.
